// File: rtl/sign_extend_18_32.sv
// Widens an IN_W-bit immediate to OUT_W bits by sign or zero extension.
// A combinational result is provided alongside a registered, valid-qualified copy.
module sign_extend_18_32 #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  A,
  input  logic             zext,
  input  logic             in_valid,
  output logic [OUT_W-1:0] S,
  output logic             neg,
  output logic [OUT_W-1:0] S_q,
  output logic             out_valid
);

  // Reject widths that would make the extension meaningless.
  generate
    if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
      $error("sign_extend_18_32: IN_W must satisfy 1 <= IN_W <= OUT_W");
    end
  endgenerate

  logic             ext_bit;
  logic [OUT_W-1:0] s_ext;

  assign ext_bit = zext ? 1'b0 : A[IN_W-1];

  // A full-width field needs no upper fill, so the concatenation is split out.
  generate
    if (IN_W == OUT_W) begin : g_same_width
      assign s_ext = A;
    end else begin : g_widen
      assign s_ext = {{(OUT_W-IN_W){ext_bit}}, A};
    end
  endgenerate

  assign S   = s_ext;
  assign neg = A[IN_W-1] & ~zext;

  logic [OUT_W-1:0] s_reg_d, s_reg_q;
  logic             valid_d, valid_q;

  always_comb begin
    s_reg_d = s_reg_q;
    valid_d = 1'b0;
    if (in_valid) begin
      s_reg_d = s_ext;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg_q <= '0;
      valid_q <= 1'b0;
    end else begin
      s_reg_q <= s_reg_d;
      valid_q <= valid_d;
    end
  end

  assign S_q       = s_reg_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sign_extend_18_32.sv
// Directed and random checks of the combinational and registered extension paths.
module tb_sign_extend_18_32;

  logic        clk;
  logic        reset;
  logic [17:0] A;
  logic        zext;
  logic        in_valid;
  logic [31:0] S;
  logic        neg;
  logic [31:0] S_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  sign_extend_18_32 #(.IN_W(18), .OUT_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .zext     (zext),
    .in_valid (in_valid),
    .S        (S),
    .neg      (neg),
    .S_q      (S_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [17:0] a, input logic z);
    return z ? {14'b0, a} : {{14{a[17]}}, a};
  endfunction

  logic [31:0] exp_s;
  logic [31:0] prev_s;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    zext     = 1'b0;

    // Combinational path
    A = 18'h00EC6; zext = 1'b0; #10;
    $display("comb A=%h zext=%b S=%h neg=%b", A, zext, S, neg);
    check("pos_S", S, 32'h00000EC6);
    check("pos_neg", {31'b0, neg}, 32'd0);

    A = 18'h3FFD5; zext = 1'b0; #10;
    $display("comb A=%h zext=%b S=%h neg=%b", A, zext, S, neg);
    check("neg_S", S, 32'hFFFFFFD5);
    check("neg_signed", $signed(S), -32'sd43);
    check("neg_neg", {31'b0, neg}, 32'd1);

    zext = 1'b1; #10;
    $display("comb A=%h zext=%b S=%h neg=%b", A, zext, S, neg);
    check("zext_S", S, 32'h0003FFD5);
    check("zext_neg", {31'b0, neg}, 32'd0);

    zext = 1'b0;
    A = 18'h1FFFF; #10; $display("comb A=%h S=%h", A, S); check("max_pos", S, 32'h0001FFFF);
    A = 18'h20000; #10; $display("comb A=%h S=%h", A, S); check("min_neg", S, 32'hFFFE0000);
    A = 18'h00000; #10; $display("comb A=%h S=%h", A, S); check("zero", S, 32'h00000000);
    A = 18'h3FFFF; #10; $display("comb A=%h S=%h", A, S); check("all_ones", S, 32'hFFFFFFFF);

    // Registered path: reset held for two edges
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("reset S_q=%h out_valid=%b", S_q, out_valid);
    check("rst_Sq", S_q, 32'h0);
    check("rst_ov", {31'b0, out_valid}, 32'd0);

    reset = 1'b0; in_valid = 1'b1; A = 18'h3FFD5; zext = 1'b0;
    @(negedge clk);
    $display("reg1 S_q=%h out_valid=%b", S_q, out_valid);
    check("reg1_Sq", S_q, 32'hFFFFFFD5);
    check("reg1_ov", {31'b0, out_valid}, 32'd1);

    A = 18'h00EC6;
    @(negedge clk);
    $display("reg2 S_q=%h out_valid=%b", S_q, out_valid);
    check("reg2_Sq", S_q, 32'h00000EC6);
    check("reg2_ov", {31'b0, out_valid}, 32'd1);

    in_valid = 1'b0; A = 18'h3FFD5;
    @(negedge clk);
    $display("hold S_q=%h out_valid=%b", S_q, out_valid);
    check("hold_Sq", S_q, 32'h00000EC6);
    check("hold_ov", {31'b0, out_valid}, 32'd0);

    reset = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    $display("rst_prio S_q=%h out_valid=%b", S_q, out_valid);
    check("prio_Sq", S_q, 32'h0);
    check("prio_ov", {31'b0, out_valid}, 32'd0);

    // Random sweep with in_valid high every cycle
    reset = 1'b0; in_valid = 1'b1;
    prev_s = '0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) begin
        check("rnd_Sq", S_q, prev_s);
        check("rnd_ov", {31'b0, out_valid}, 32'd1);
      end
      A    = 18'($urandom);
      zext = 1'($urandom_range(0, 1));
      #1;
      exp_s = ref_ext(A, zext);
      if (i % 100 == 0) $display("rnd %0d A=%h zext=%b S=%h", i, A, zext, S);
      check("rnd_S", S, exp_s);
      check("rnd_neg", {31'b0, neg}, {31'b0, A[17] & ~zext});
      prev_s = exp_s;
      @(negedge clk);
    end
    check("rnd_Sq_last", S_q, prev_s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_extend_18_32.md
Name: sign_extend_18_32

Overview:
- Sign-extension unit that widens an 18-bit two's-complement immediate to a 32-bit datapath word.
- Sits in the CPU datapath between instruction decode (18-bit immediate field) and the ALU/address adders.
- Provides a zero-latency combinational result for single-cycle datapaths, plus a registered, valid-qualified copy for pipelined use.
- Also supports a zero-extend mode for unsigned immediates.

Parameters:
- IN_W, 18, input field width in bits; must satisfy 1 <= IN_W <= OUT_W.
- OUT_W, 32, output word width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- A  input  IN_W  immediate field to extend.
- zext  input  1  0 = sign-extend, 1 = zero-extend.
- in_valid  input  1  A/zext are valid this cycle; controls loading of the registered path.
- S  output  OUT_W  combinational extended result.
- neg  output  1  combinational; equals A[IN_W-1] AND NOT zext.
- S_q  output  OUT_W  registered extended result.
- out_valid  output  1  registered; S_q holds a result captured from a valid input.

Behaviour:
Combinational path (no clock dependency):
- zext=0: S[IN_W-1:0] = A; S[OUT_W-1:IN_W] = replicated A[IN_W-1].
- zext=1: S[IN_W-1:0] = A; S[OUT_W-1:IN_W] = 0.
- When the MSB of A is 0, both modes give the same S, and S is numerically equal to A.
- When A[17]=1 and zext=0, $signed(S) == $signed(A). Example: A=18'h3FFD5 (-43) gives S=32'hFFFFFFD5.
- S and neg update within the same delta as A and zext; there is no latch and no dependence on clk or reset.
- If A or zext is X or Z, S is X. No X-masking.

Registered path:
- On a rising clk edge with reset=1: S_q <= 0 and out_valid <= 0. Reset has priority over in_valid.
- On a rising clk edge with reset=0 and in_valid=1: S_q <= S (the current combinational value) and out_valid <= 1. Latency is one cycle.
- On a rising clk edge with reset=0 and in_valid=0: S_q holds its value and out_valid <= 0.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- Asserting reset mid-stream clears the register path on that edge. The combinational S is unaffected by reset.
- Before the first clock edge, S_q and out_valid are undefined. The bench must apply reset for at least 1 cycle before relying on them.

Width rules:
- If IN_W == OUT_W, S = A in both modes.
- The elaboration must fail if IN_W > OUT_W or IN_W < 1.

Test Plan:
- Positive value: A=3782 (18'h00EC6), zext=0, wait 10 time units with no clock -> S=32'h00000EC6 (equal to A), neg=0.
- Negative value: A=-43 (18'h3FFD5), zext=0 -> S=32'hFFFFFFD5, $signed(S)=-43, neg=1. Same A with zext=1 -> S=32'h0003FFD5, neg=0.
- Boundaries, zext=0:
  - A=18'h1FFFF -> S=32'h0001FFFF.
  - A=18'h20000 -> S=32'hFFFE0000.
  - A=0 -> S=0.
  - A=18'h3FFFF -> S=32'hFFFFFFFF.
- Registered path:
  - reset=1 for 2 cycles -> S_q=0, out_valid=0.
  - Release reset; in_valid=1 with A=-43, then A=3782 on consecutive cycles -> S_q=32'hFFFFFFD5 with out_valid=1 one cycle after the first input, then 32'h00000EC6 the next cycle.
- Hold and reset priority:
  - in_valid=0 -> S_q holds its last value and out_valid drops to 0 on the next edge.
  - reset=1 together with in_valid=1 -> S_q=0 and out_valid=0 after that edge.
- Random sweep: 1000 random A and zext values -> S matches the reference model (sign- or zero-extension) every time. With in_valid=1 on every cycle, S_q equals the previous cycle's S.
